// File: rtl/data_ram_arbiter.sv
// Shares a single-port synchronous-read data RAM between the CPU load/store path
// and a debug/loader port: one-cycle writes, two-cycle reads, CPU stalled when not served.
module data_ram_arbiter #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int MAX_CPU_RUN = 4
) (
  input  logic              MAX10_CLK1_50,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [1:0] ST_ISSUE  = 2'd0;
  localparam logic [1:0] ST_CPU_RD = 2'd1;
  localparam logic [1:0] ST_DBG_RD = 2'd2;
  localparam logic [3:0] RUN_LIMIT = 4'(MAX_CPU_RUN);

  logic [1:0]        r_state;
  logic [1:0]        w_state_next;
  logic [3:0]        r_starve_cnt;
  logic [3:0]        w_starve_next;
  logic [DATA_W-1:0] r_dbg_rdata;
  logic              r_dbg_rvalid;

  logic              w_in_issue;
  logic              w_dbg_win;
  logic              w_cpu_win;
  logic              w_win_we;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_wdata;

  assign w_in_issue = (r_state == ST_ISSUE);
  // CPU has priority unless it is idle or debug has waited through MAX_CPU_RUN CPU grants.
  assign w_dbg_win  = w_in_issue && dbg_req && (!cpu_req || (r_starve_cnt == RUN_LIMIT));
  assign w_cpu_win  = w_in_issue && cpu_req && !w_dbg_win;

  always_comb begin
    w_win_we    = 1'b0;
    w_win_addr  = '0;
    w_win_wdata = '0;
    if (w_dbg_win) begin
      w_win_we    = dbg_we;
      w_win_addr  = dbg_addr;
      w_win_wdata = dbg_wdata;
    end else if (w_cpu_win) begin
      w_win_we    = cpu_we;
      w_win_addr  = cpu_addr;
      w_win_wdata = cpu_wdata;
    end
  end

  always_comb begin
    w_state_next = ST_ISSUE;
    if ((w_dbg_win || w_cpu_win) && !w_win_we) begin
      w_state_next = w_dbg_win ? ST_DBG_RD : ST_CPU_RD;
    end
  end

  always_comb begin
    w_starve_next = r_starve_cnt;
    if (!dbg_req || w_dbg_win) begin
      w_starve_next = '0;
    end else if (w_cpu_win && (r_starve_cnt < RUN_LIMIT)) begin
      w_starve_next = r_starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset) begin
      r_state      <= ST_ISSUE;
      r_starve_cnt <= '0;
      r_dbg_rdata  <= '0;
      r_dbg_rvalid <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_starve_cnt <= w_starve_next;
      r_dbg_rvalid <= (r_state == ST_DBG_RD);
      if (r_state == ST_DBG_RD) begin
        r_dbg_rdata <= ram_rdata;
      end
    end
  end

  // Reset gates every combinational output so nothing leaks to the RAM or CPU.
  assign ram_we     = !reset && w_win_we;
  assign ram_addr   = reset ? '0 : w_win_addr;
  assign ram_wdata  = reset ? '0 : w_win_wdata;
  assign dbg_gnt    = !reset && w_dbg_win;
  assign dbg_rvalid = r_dbg_rvalid;
  assign dbg_rdata  = r_dbg_rdata;
  assign cpu_rdata  = (!reset && (r_state == ST_CPU_RD)) ? ram_rdata : '0;
  assign cpu_stall  = !reset && cpu_req && (r_state != ST_CPU_RD) && !(w_cpu_win && cpu_we);

endmodule
